// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and width helper for the elastic pipeline register chain
// Optional build macro: PIPE_SKID_EN (adds one skid entry ahead of stage 0)
package pipe_pkg;

  // Per-stage handshake view: valid held by the stage, ready computed for its load
  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_ctrl_t;

  // Occupancy width: one extra count slot when the skid entry exists
  function automatic int occ_width(input int stages);
`ifdef PIPE_SKID_EN
    return $clog2(stages + 2);
`else
    return $clog2(stages + 1);
`endif
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data register of the elastic chain with load and flush
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int             N         = 64,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         up_valid,
  input  logic [N-1:0] up_data,
  output logic         valid,
  output logic [N-1:0] data
);

  // Valid follows upstream on load; flush wins; data only moves with a real entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= up_valid;
      end
      if (load && up_valid && !flush) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - parametrised elastic pipeline register chain with stall, bubble collapse and flush
// Optional build macro: PIPE_SKID_EN (skid entry ahead of stage 0, in_ready driven from a flop)
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int           N         = 64,
  parameter int           STAGES    = 3,
  parameter logic [N-1:0] RESET_VAL = '0,
  localparam int          OCC_W     = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0]            valid_q;
  logic [N-1:0]                 data_q [STAGES];
  pipe_ctrl_t [STAGES-1:0]      ctrl;
  logic                         ready_acc;
  logic                         head_valid;
  logic [N-1:0]                 head_data;
  logic [OCC_W-1:0]             occ_c;

  // Ready chain unrolled from the output side: a stage is ready if it or any later stage has a hole
  always_comb begin
    ctrl      = '0;
    ready_acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_acc     = ready_acc || !valid_q[i];
      ctrl[i].valid = valid_q[i];
      ctrl[i].ready = ready_acc;
    end
  end

`ifdef PIPE_SKID_EN
  logic         skid_valid;
  logic [N-1:0] skid_data;

  assign in_ready   = !skid_valid && !flush;
  assign head_valid = skid_valid || in_valid;
  assign head_data  = skid_valid ? skid_data : in_data;

  // Skid catches an accepted input that stage 0 cannot take and hands it on first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (ctrl[0].ready) begin
        skid_valid <= 1'b0;
      end
    end else if (in_valid && !ctrl[0].ready) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready   = ctrl[0].ready && !flush;
  assign head_valid = in_valid;
  assign head_data  = in_data;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic         up_v;
    logic [N-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = head_valid;
      assign up_d = head_data;
    end else begin : g_body
      assign up_v = ctrl[i-1].valid;
      assign up_d = data_q[i-1];
    end
    pipe_stage #(
      .N         (N),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (ctrl[i].ready),
      .up_valid (up_v),
      .up_data  (up_d),
      .valid    (valid_q[i]),
      .data     (data_q[i])
    );
  end

  // Popcount of every held entry, deliberately not masked by flush
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_c = occ_c + OCC_W'(valid_q[i]);
    end
`ifdef PIPE_SKID_EN
    occ_c = occ_c + OCC_W'(skid_valid);
`endif
  end

  assign occupancy = occ_c;
  assign out_valid = ctrl[STAGES-1].valid && !flush;
  assign out_data  = data_q[STAGES-1];

  // Producer must hold a refused offer steady (a flush cycle releases it)
  a_in_hold : assert property (
    @(posedge clk) disable iff (reset)
    (in_valid && !in_ready && !flush) |=> (in_valid && (in_data == $past(in_data)))
  );

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - scoreboard bench for pipe_reg_chain (N=8, STAGES=3)
module tb_pipe_reg_chain;

  localparam int N      = 8;
  localparam int STAGES = 3;
`ifdef PIPE_SKID_EN
  localparam int CAP    = STAGES + 1;
  localparam int OCC_W  = $clog2(STAGES + 2);
`else
  localparam int CAP    = STAGES;
  localparam int OCC_W  = $clog2(STAGES + 1);
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [OCC_W-1:0] occupancy;

  typedef struct {
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb [$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  bit   lat_chk    = 0;

  pipe_reg_chain #(
    .N         (N),
    .STAGES    (STAGES),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset || flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output got %h required none", out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.data) begin
              miscompares++;
              $display("FAIL out_data got %h required %h", out_data, e.data);
            end
            if (lat_chk) begin
              vectors++;
              if ((cyc - e.cyc) != STAGES) begin
                miscompares++;
                $display("FAIL latency got %0d required %0d", cyc - e.cyc, STAGES);
              end
            end
          end
        end
        if (in_valid && in_ready) sb.push_back('{in_data, cyc});
      end
    end
  endtask

  task automatic send(input logic [N-1:0] d, output int waits, output logic [OCC_W-1:0] occ_at);
    bit ok;
    ok = 0; waits = 0; occ_at = '0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        occ_at = occupancy;
      end else begin
        waits++;
      end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout got no accept required accept of %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending required 0", sb.size());
    end
    @(posedge clk); #1;
    vectors++;
    if (occupancy !== OCC_W'(0)) begin
      miscompares++;
      $display("FAIL drain_occupancy got %0d required 0", occupancy);
    end
  endtask

  task automatic fill(input logic [N-1:0] base);
    int w; logic [OCC_W-1:0] o;
    out_ready = 1'b0;
    for (int k = 0; k < CAP; k++) send(base + N'(k), w, o);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data got %h required 00", out_data); end
    if (occupancy !== OCC_W'(0)) begin miscompares++; $display("FAIL rst_occupancy got %0d required 0", occupancy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    fill(8'h71);
    vectors++;
    if (occupancy !== OCC_W'(CAP)) begin miscompares++; $display("FAIL fill_occupancy got %0d required %0d", occupancy, CAP); end
    #1 reset = 1'b1;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_out_valid got %b required 0", out_valid); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL async_out_data got %h required 00", out_data); end
    if (occupancy !== OCC_W'(0)) begin miscompares++; $display("FAIL async_occupancy got %0d required 0", occupancy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_in_ready got %b required 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int w; logic [OCC_W-1:0] o;
    out_ready = 1'b1;
    lat_chk = 1;
    for (int i = 0; i < 10; i++) begin
      send(N'(i + 1), w, o);
      vectors++;
      if (w != 0) begin miscompares++; $display("FAIL stream_stall got %0d waits required 0", w); end
      if (i >= STAGES) begin
        vectors++;
        if (o !== OCC_W'(STAGES)) begin miscompares++; $display("FAIL stream_occupancy got %0d required %0d", o, STAGES); end
      end
    end
    drain();
    lat_chk = 0;
  endtask

  task automatic test_backpressure();
    int w; logic [OCC_W-1:0] o;
    out_ready = 1'b0;
    send(8'h11, w, o);
    send(8'h22, w, o);
    send(8'h33, w, o);
`ifdef PIPE_SKID_EN
    send(8'h44, w, o);
    vectors++;
    if (w != 0) begin miscompares++; $display("FAIL skid_accept got %0d waits required 0", w); end
    #1;
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full_in_ready got %b required 0", in_ready); end
    if (occupancy !== OCC_W'(4)) begin miscompares++; $display("FAIL skid_peak_occupancy got %0d required 4", occupancy); end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_comb_path got %b required 0", in_ready); end
    out_ready = 1'b0;
    #1;
`else
    in_valid = 1'b1;
    in_data  = 8'h44;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors += 2;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
      if (occupancy !== OCC_W'(STAGES)) begin miscompares++; $display("FAIL bp_occupancy got %0d required %0d", occupancy, STAGES); end
    end
    @(posedge clk); #1;
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_gap got out_valid %b required 1 at slot %0d", out_valid, k); end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    drain();
  endtask

  task automatic test_bubble();
    int w; logic [OCC_W-1:0] o;
    out_ready = 1'b0;
    send(8'hA1, w, o);
    @(posedge clk); #1;
    send(8'hA2, w, o);
    vectors += 3;
    if (w != 0) begin miscompares++; $display("FAIL bubble_stall got %0d waits required 0", w); end
    if (occupancy !== OCC_W'(2)) begin miscompares++; $display("FAIL bubble_occupancy got %0d required 2", occupancy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_in_ready got %b required 1", in_ready); end
    drain();
  endtask

  task automatic test_flush();
    fill(8'h61);
    in_valid = 1'b1;
    in_data  = 8'h55;
    flush    = 1'b1;
    #1;
    vectors += 3;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %b required 0", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %b required 0", out_valid); end
    if (occupancy !== OCC_W'(CAP)) begin miscompares++; $display("FAIL flush_occupancy got %0d required %0d", occupancy, CAP); end
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors += 3;
    if (occupancy !== OCC_W'(0)) begin miscompares++; $display("FAIL post_flush_occupancy got %0d required 0", occupancy); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_flush_out_valid got %b required 0", out_valid); end
    if (out_data !== 8'h61) begin miscompares++; $display("FAIL post_flush_data_held got %h required 61", out_data); end
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
